// File: rtl/spi_slave_ram_param.sv
// rtl/spi_slave_ram_param.sv - parametrised SPI slave with command-driven single-port RAM
module spi_slave_ram_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);

    localparam int FRAME_W = DATA_WIDTH + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]      LAST_IN_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]      OUT_BITS    = CNT_W'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, SHIFT, EXEC, READ_OUT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [FRAME_W-1:0]     frame_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]  rd_word, out_q;

    logic [1:0]             cmd;
    logic [DATA_WIDTH-1:0]  payload;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   addr_ok;

    logic shift_in, wr_ptr_set, rd_ptr_set, wr_ptr_inc, rd_ptr_inc;
    logic ram_we, rd_fetch, out_load, out_shift, err;

    assign cmd     = frame_q[FRAME_W-1 -: 2];
    assign payload = frame_q[DATA_WIDTH-1:0];
    assign addr    = payload[ADDR_WIDTH-1:0];
    assign addr_ok = {1'b0, addr} < DEPTH_EXT;
    assign busy    = (state_q != IDLE);

    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-edge control strobes; SS_n high mid-frame aborts
    always_comb begin
        state_d    = state_q;
        shift_in   = 1'b0;
        wr_ptr_set = 1'b0;
        rd_ptr_set = 1'b0;
        wr_ptr_inc = 1'b0;
        rd_ptr_inc = 1'b0;
        ram_we     = 1'b0;
        rd_fetch   = 1'b0;
        out_load   = 1'b0;
        out_shift  = 1'b0;
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!SS_n) begin
                    shift_in = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (SS_n) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    shift_in = 1'b1;
                    if (bit_cnt == LAST_IN_BIT) state_d = EXEC;
                end
            end
            EXEC: begin
                if (SS_n) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    case (cmd)
                        2'b00: begin
                            if (addr_ok) wr_ptr_set = 1'b1;
                            else         err        = 1'b1;
                        end
                        2'b01: begin
                            ram_we     = 1'b1;
                            wr_ptr_inc = AUTO_INC;
                        end
                        2'b10: begin
                            if (addr_ok) rd_ptr_set = 1'b1;
                            else         err        = 1'b1;
                        end
                        default: begin
                            rd_fetch   = 1'b1;
                            rd_ptr_inc = AUTO_INC;
                            state_d    = READ_OUT;
                        end
                    endcase
                end
            end
            READ_OUT: begin
                if (SS_n) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else if (bit_cnt == OUT_BITS) begin
                    state_d = DONE;
                end else if (bit_cnt == '0) begin
                    out_load = 1'b1;
                end else begin
                    out_shift = 1'b1;
                end
            end
            DONE: begin
                if (SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame capture, bit counting, pointers and MISO; MISO falls to 0 unless shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q   <= '0;
            bit_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_q     <= '0;
            MISO      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err;
            if (shift_in) frame_q <= {frame_q[FRAME_W-2:0], MOSI};

            if (shift_in)
                bit_cnt <= (state_q == IDLE) ? CNT_W'(1) : bit_cnt + CNT_W'(1);
            else if (out_load || out_shift)
                bit_cnt <= bit_cnt + CNT_W'(1);
            else
                bit_cnt <= '0;

            if (wr_ptr_set)      wr_ptr <= addr;
            else if (wr_ptr_inc) wr_ptr <= ptr_next(wr_ptr);
            if (rd_ptr_set)      rd_ptr <= addr;
            else if (rd_ptr_inc) rd_ptr <= ptr_next(rd_ptr);

            if (out_load) begin
                MISO  <= rd_word[DATA_WIDTH-1];
                out_q <= rd_word << 1;
            end else if (out_shift) begin
                MISO  <= out_q[DATA_WIDTH-1];
                out_q <= out_q << 1;
            end else begin
                MISO  <= 1'b0;
            end
        end
    end

    // RAM array is never reset; writes are suppressed on a reset edge
    always_ff @(posedge clk) begin
        if (!rst && ram_we)   mem[wr_ptr] <= payload;
        if (!rst && rd_fetch) rd_word     <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_spi_slave_ram_param.sv
// tb/tb_spi_slave_ram_param.sv - self-checking bench for spi_slave_ram_param
module tb_spi_slave_ram_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ss_n, mosi, miso, busy, ferr;

    int tests = 0;
    int fails = 0;

    logic [7:0] mdl [3][256];
    int         wp [3];
    int         rp [3];

    always #5 clk = ~clk;

    spi_slave_ram_param u_dut0 (
        .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .busy(busy[0]), .frame_err(ferr[0])
    );

    spi_slave_ram_param #(.AUTO_INC(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .busy(busy[1]), .frame_err(ferr[1])
    );

    spi_slave_ram_param #(.MEM_DEPTH(200)) u_dut2 (
        .clk(clk), .rst(rst), .SS_n(ss_n[2]), .MOSI(mosi[2]),
        .MISO(miso[2]), .busy(busy[2]), .frame_err(ferr[2])
    );

    function automatic int depth_of(input int sel);
        return (sel == 2) ? 200 : 256;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int sel, input logic [1:0] cmd, input logic [7:0] pl,
                             input int abort_at, output logic [7:0] rd, output int fe,
                             output logic miso_bad, output logic busy_end);
        logic [9:0] bits;
        bits     = {cmd, pl};
        rd       = '0;
        fe       = 0;
        miso_bad = 1'b0;
        busy_end = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            ss_n[sel] = (k == abort_at);
            mosi[sel] = (k <= 10) ? bits[10-k] : 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (ferr[sel]) fe++;
            if (k == abort_at) begin
                if (miso[sel] !== 1'b0) miso_bad = 1'b1;
                busy_end = busy[sel];
                break;
            end
            if (k >= 12 && k <= 19) rd[19-k] = miso[sel];
            else if (miso[sel] !== 1'b0) miso_bad = 1'b1;
        end
        ss_n[sel] = 1'b1;
        mosi[sel] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (ferr[sel]) fe++;
        if (abort_at == 0) busy_end = busy[sel];
    endtask

    task automatic do_frame(input int sel, input logic [1:0] cmd, input logic [7:0] pl,
                            input int abort_at, input string tag);
        logic [7:0] rd, exp_rd;
        int         fe, exp_fe, depth;
        logic       miso_bad, busy_end;
        bit         commit;
        depth  = depth_of(sel);
        exp_rd = '0;
        exp_fe = 0;
        commit = (abort_at == 0) || (abort_at > 11);
        if (abort_at >= 2 && (abort_at <= 11 || (cmd == 2'b11 && abort_at <= 20))) exp_fe = 1;
        if (commit) begin
            case (cmd)
                2'b00: if (int'(pl) < depth) wp[sel] = int'(pl); else exp_fe++;
                2'b01: begin
                    mdl[sel][wp[sel]] = pl;
                    if (sel == 1) wp[sel] = (wp[sel] + 1) % depth;
                end
                2'b10: if (int'(pl) < depth) rp[sel] = int'(pl); else exp_fe++;
                default: begin
                    exp_rd = mdl[sel][rp[sel]];
                    if (sel == 1) rp[sel] = (rp[sel] + 1) % depth;
                end
            endcase
        end
        if (abort_at >= 12)
            for (int k = 12; k <= 19; k++)
                if (k >= abort_at) exp_rd[19-k] = 1'b0;
        run_frame(sel, cmd, pl, abort_at, rd, fe, miso_bad, busy_end);
        check({tag, "/rd"}, 32'(rd), 32'(exp_rd));
        check({tag, "/frame_err"}, 32'(fe), 32'(exp_fe));
        check({tag, "/miso_idle"}, 32'(miso_bad), 32'd0);
        check({tag, "/busy_end"}, 32'(busy_end), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [9:0] bits;
        rst  = 1'b1;
        ss_n = 3'b111;
        mosi = 3'b000;
        for (int s = 0; s < 3; s++) begin
            wp[s] = 0;
            rp[s] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/miso", 32'(miso), 32'd0);
        check("reset/frame_err", 32'(ferr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_frame(0, 2'b00, 8'h05, 0, "t1_setwr");
        do_frame(0, 2'b01, 8'hA7, 0, "t1_write");
        do_frame(0, 2'b10, 8'h05, 0, "t1_setrd");
        do_frame(0, 2'b11, 8'h00, 0, "t1_read");

        for (int i = 0; i < 10; i++) begin
            d = 8'(($urandom & 32'hF0) | i);
            do_frame(0, 2'b00, 8'(i), 0, "t2_setwr");
            do_frame(0, 2'b01, d, 0, "t2_write");
            do_frame(0, 2'b10, 8'(i), 0, "t2_setrd");
            do_frame(0, 2'b11, 8'($urandom), 0, "t2_read");
        end

        do_frame(1, 2'b00, 8'hFE, 0, "t3_setwr");
        do_frame(1, 2'b01, 8'h11, 0, "t3_w0");
        do_frame(1, 2'b01, 8'h22, 0, "t3_w1");
        do_frame(1, 2'b01, 8'h33, 0, "t3_w2");
        do_frame(1, 2'b10, 8'hFE, 0, "t3_setrd");
        do_frame(1, 2'b11, 8'h00, 0, "t3_r0");
        do_frame(1, 2'b11, 8'h00, 0, "t3_r1");
        do_frame(1, 2'b11, 8'h00, 0, "t3_r2");

        do_frame(0, 2'b00, 8'h20, 0, "t4_setwr");
        do_frame(0, 2'b01, 8'h3C, 0, "t4_write");
        do_frame(0, 2'b01, 8'hFF, 7, "t4_abort_wr");
        do_frame(0, 2'b10, 8'h20, 0, "t4_setrd");
        do_frame(0, 2'b11, 8'h00, 0, "t4_read");
        do_frame(0, 2'b11, 8'h00, 14, "t4_abort_rd");
        do_frame(0, 2'b11, 8'h00, 0, "t4_reread");

        do_frame(2, 2'b00, 8'h10, 0, "t5_setwr");
        do_frame(2, 2'b00, 8'hC8, 0, "t5_oor_wr");
        do_frame(2, 2'b01, 8'h5A, 0, "t5_write");
        do_frame(2, 2'b10, 8'hC8, 0, "t5_oor_rd");
        do_frame(2, 2'b10, 8'h10, 0, "t5_setrd");
        do_frame(2, 2'b11, 8'h00, 0, "t5_read");
        do_frame(2, 2'b00, 8'hC7, 0, "t5_setwr_last");
        do_frame(2, 2'b01, 8'h77, 0, "t5_write_last");
        do_frame(2, 2'b10, 8'hC7, 0, "t5_setrd_last");
        do_frame(2, 2'b11, 8'h00, 0, "t5_read_last");

        do_frame(0, 2'b10, 8'h07, 0, "t6_setrd");
        bits = {2'b10, 8'h03};
        for (int k = 1; k <= 4; k++) begin
            ss_n[0] = 1'b0;
            mosi[0] = bits[10-k];
            @(posedge clk);
            @(negedge clk);
        end
        check("t6/busy_mid", 32'(busy[0]), 32'd1);
        rst     = 1'b1;
        ss_n[0] = 1'b1;
        mosi[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6/busy_rst", 32'(busy[0]), 32'd0);
        check("t6/miso_rst", 32'(miso[0]), 32'd0);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            wp[s] = 0;
            rp[s] = 0;
        end
        @(negedge clk);
        do_frame(0, 2'b11, 8'h00, 0, "t6_read0");
        do_frame(1, 2'b11, 8'h00, 0, "t6_read0_ai");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
